fanout_stim_sequencer: RTL and testbench

FANOUT_STIM_SEQUENCER -- requirements
Module: fanout_stim_sequencer

---
 rtl/fanout_stim_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_fanout_stim_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_stim_sequencer.sv
// fanout_stim_sequencer: drives a pulse train into a NOR fanout chain and
// counts the edges that come back on four asynchronous branch outputs.
// Each run is HIGH/LOW pulses, a DRAIN settle window, then a one-cycle DONE.
// Per-branch edge counts are compared against 2*pulse_count at DONE.
module fanout_stim_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  pulse_width,
  input  logic [7:0]  gap_width,
  input  logic [7:0]  pulse_count,
  output logic        stim_out,
  input  logic [3:0]  branch_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] edge_cnt,
  output logic [3:0]  mismatch
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Phase counters hold (length - 1); a zero width behaves like a width of one.
  function automatic logic [7:0] phase_load(input logic [7:0] width);
    return (width == 8'd0) ? 8'd0 : (width - 8'd1);
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic [7:0]           r_pw;
  logic [7:0]           r_gap;
  logic [7:0]           r_cnt;
  logic [7:0]           r_phase;
  logic [7:0]           r_left;
  logic [DRAIN_W-1:0]   r_drain;
  logic                 r_stim;
  logic                 r_busy;
  logic                 r_done;
  logic [SYNC_STAGES-1:0] r_sync [4];
  logic [3:0]           r_br_d;
  logic [3:0]           w_br_s;
  logic [3:0]           w_edge;
  logic                 w_count_en;
  logic [7:0]           r_edge [4];
  logic [3:0]           r_mismatch;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_count_en = (r_state == HIGH) || (r_state == LOW) || (r_state == DRAIN);

  // Next-state decode for the run sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (pulse_count == 8'd0) ? DRAIN : HIGH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HIGH: begin
        if (r_phase == 8'd0) begin
          w_state_nxt = LOW;
        end else begin
          w_state_nxt = HIGH;
        end
      end
      LOW: begin
        if (r_phase == 8'd0) begin
          w_state_nxt = (r_left != 8'd0) ? HIGH : DRAIN;
        end else begin
          w_state_nxt = LOW;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_W'(0)) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are flops decoded from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_stim <= (w_state_nxt == HIGH);
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
    end
  end

  // Latched run configuration plus phase, pulse and drain timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pw    <= 8'd0;
      r_gap   <= 8'd0;
      r_cnt   <= 8'd0;
      r_phase <= 8'd0;
      r_left  <= 8'd0;
      r_drain <= DRAIN_W'(0);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pw    <= pulse_width;
            r_gap   <= gap_width;
            r_cnt   <= pulse_count;
            r_phase <= phase_load(pulse_width);
            r_left  <= pulse_count;
          end
        end
        HIGH: begin
          if (r_phase == 8'd0) begin
            r_phase <= phase_load(r_gap);
            r_left  <= r_left - 8'd1;
          end else begin
            r_phase <= r_phase - 8'd1;
          end
        end
        LOW: begin
          if (r_phase == 8'd0) begin
            r_phase <= phase_load(r_pw);
          end else begin
            r_phase <= r_phase - 8'd1;
          end
        end
        default: r_phase <= r_phase;
      endcase
      // Drain timer stays preloaded until DRAIN is entered.
      if (r_state == DRAIN) begin
        if (r_drain != DRAIN_W'(0)) begin
          r_drain <= r_drain - DRAIN_W'(1);
        end
      end else begin
        r_drain <= DRAIN_W'(DRAIN_CYCLES - 1);
      end
    end
  end

  // Multi-flop synchronizers and one-cycle history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_sync[i] <= '0;
      end
      r_br_d <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], branch_in[i]};
      end
      r_br_d <= w_br_s;
    end
  end

  // Synchronized branch levels and per-branch edge pulses.
  always_comb begin
    w_br_s = 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_br_s[i] = r_sync[i][SYNC_STAGES-1];
    end
    w_edge = w_br_s ^ r_br_d;
  end

  // Saturating per-branch edge counters and end-of-run mismatch flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_edge[i] <= 8'd0;
      end
      r_mismatch <= 4'd0;
    end else if (w_accept) begin
      for (int i = 0; i < 4; i++) begin
        r_edge[i] <= 8'd0;
      end
      r_mismatch <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_count_en && w_edge[i] && (r_edge[i] != 8'd255)) begin
          r_edge[i] <= r_edge[i] + 8'd1;
        end
        if (r_state == DONE) begin
          r_mismatch[i] <= ({1'b0, r_edge[i]} != {r_cnt, 1'b0});
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt_out
    assign edge_cnt[8*g +: 8] = r_edge[g];
  end

  assign stim_out = r_stim;
  assign busy     = r_busy;
  assign done     = r_done;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_fanout_stim_sequencer.sv
// Bench for fanout_stim_sequencer: models four fanout branches (delayed
// follower, tied low, or free-running toggle), predicts the stim/done waveform
// and end-of-run counts, and compares them against the design.
module tb_fanout_stim_sequencer;

  localparam int DRAIN = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  pulse_width;
  logic [7:0]  gap_width;
  logic [7:0]  pulse_count;
  logic        stim_out;
  logic [3:0]  branch_in;
  logic        busy;
  logic        done;
  logic [31:0] edge_cnt;
  logic [3:0]  mismatch;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] ec;
    logic [3:0]  mm;
  } res_t;

  res_t       res_q[$];
  logic [1:0] wave_q[$];

  // Branch modes: 0 = follow stim_out 5 cycles late, 1 = tied low, 2 = toggle every cycle.
  logic [1:0] bmode [4];
  logic [4:0] r_dly = 5'd0;
  logic       r_tog = 1'b0;

  always #5 clk = ~clk;

  fanout_stim_sequencer #(.SYNC_STAGES(2), .DRAIN_CYCLES(DRAIN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pulse_width (pulse_width),
    .gap_width   (gap_width),
    .pulse_count (pulse_count),
    .stim_out    (stim_out),
    .branch_in   (branch_in),
    .busy        (busy),
    .done        (done),
    .edge_cnt    (edge_cnt),
    .mismatch    (mismatch)
  );

  // Fanout chain model: delay line and toggle source.
  always @(posedge clk) begin
    r_dly <= {r_dly[3:0], stim_out};
    r_tog <= ~r_tog;
  end

  // Branch output selection per mode.
  always_comb begin
    branch_in = 4'd0;
    for (int i = 0; i < 4; i++) begin
      case (bmode[i])
        2'd0:    branch_in[i] = r_dly[4];
        2'd1:    branch_in[i] = 1'b0;
        default: branch_in[i] = r_tog;
      endcase
    end
  end

  // One complete run: push expectations, drive start, check every cycle, pop results.
  task automatic do_run(input int pw, input int gap, input int cnt, input bit disturb,
                        input string name);
    res_t       r;
    res_t       q;
    int         p1, g1, c, ncyc, werr;
    logic [1:0] e, act;
    string      first;
    for (int i = 0; i < 4; i++) begin
      if (bmode[i] == 2'd0) c = (2 * cnt > 255) ? 255 : 2 * cnt;
      else if (bmode[i] == 2'd1) c = 0;
      else c = 255;  // toggle source sees far more than 255 counted cycles in its runs
      r.ec[8*i +: 8] = 8'(c);
      r.mm[i]        = (c != 2 * cnt);
    end
    res_q.push_back(r);
    p1 = (pw == 0) ? 1 : pw;
    g1 = (gap == 0) ? 1 : gap;
    wave_q.delete();
    for (int k = 0; k < cnt; k++) begin
      for (int j = 0; j < p1; j++) wave_q.push_back(2'b10);
      for (int j = 0; j < g1; j++) wave_q.push_back(2'b00);
    end
    for (int j = 0; j < DRAIN; j++) wave_q.push_back(2'b00);
    wave_q.push_back(2'b01);

    repeat (8) @(negedge clk);
    pulse_width = 8'(pw);
    gap_width   = 8'(gap);
    pulse_count = 8'(cnt);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (edge_cnt !== 32'd0 || mismatch !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_clear got edge_cnt=%h mismatch=%b expected 0/0", name, edge_cnt, mismatch);
    end

    werr = 0;
    ncyc = 0;
    first = "";
    while (wave_q.size() > 0) begin
      e   = wave_q.pop_front();
      act = {stim_out, done};
      if (act !== e || busy !== 1'b1) begin
        if (werr == 0)
          first = $sformatf("cycle %0d got stim,done=%b busy=%b expected %b busy=1",
                            ncyc + 1, act, busy, e);
        werr++;
      end
      if (disturb && ncyc == p1) begin
        start       = 1'b1;
        pulse_width = 8'd1;
        gap_width   = 8'd7;
        pulse_count = 8'd9;
      end
      if (disturb && ncyc == p1 + 1) start = 1'b0;
      ncyc++;
      @(negedge clk);
    end
    n_tests++;
    if (werr != 0) begin
      n_fail++;
      $display("FAIL %s_wave %0d bad cycles, first: %s", name, werr, first);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || stim_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle got busy=%b done=%b stim=%b expected 0/0/0", name, busy, done, stim_out);
    end
    q = res_q.pop_front();
    n_tests++;
    if (edge_cnt !== q.ec) begin
      n_fail++;
      $display("FAIL %s_edge_cnt got %h expected %h", name, edge_cnt, q.ec);
    end
    n_tests++;
    if (mismatch !== q.mm) begin
      n_fail++;
      $display("FAIL %s_mismatch got %b expected %b", name, mismatch, q.mm);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (edge_cnt !== q.ec || mismatch !== q.mm) begin
      n_fail++;
      $display("FAIL %s_hold got %h/%b expected %h/%b", name, edge_cnt, mismatch, q.ec, q.mm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pulse_width = 8'd0;
    gap_width   = 8'd0;
    pulse_count = 8'd0;
    for (int i = 0; i < 4; i++) bmode[i] = 2'd0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({stim_out, busy, done} !== 3'b000 || edge_cnt !== 32'd0 || mismatch !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got stim,busy,done=%b edge_cnt=%h mismatch=%b expected zeros",
               {stim_out, busy, done}, edge_cnt, mismatch);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || stim_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b stim=%b expected 0/0", busy, stim_out);
    end
  endtask

  task automatic test_basic();
    do_run(3, 2, 4, 1'b0, "basic");
  endtask

  task automatic test_branch_low();
    bmode[2] = 2'd1;
    do_run(3, 2, 4, 1'b0, "branch2_low");
    bmode[2] = 2'd0;
  endtask

  task automatic test_narrow();
    do_run(0, 0, 2, 1'b0, "narrow");
  endtask

  task automatic test_zero_count();
    do_run(5, 5, 0, 1'b0, "zero_count");
  endtask

  task automatic test_midrun_and_saturate();
    do_run(3, 2, 4, 1'b1, "disturb");
    bmode[1] = 2'd2;
    do_run(0, 0, 200, 1'b0, "saturate");
    bmode[1] = 2'd0;
  endtask

  task automatic test_reset_mid_run();
    int err;
    repeat (8) @(negedge clk);
    pulse_width = 8'd3;
    gap_width   = 8'd2;
    pulse_count = 8'd4;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stim_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_high got stim=%b expected 1", stim_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (stim_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || edge_cnt !== 32'd0 || mismatch !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async got stim=%b busy=%b done=%b ec=%h mm=%b expected zeros",
               stim_out, busy, done, edge_cnt, mismatch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    err = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || stim_out !== 1'b0) err++;
    end
    n_tests++;
    if (err != 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet got %0d cycles with done/busy/stim set expected 0", err);
    end
  endtask

  task automatic test_back_to_back();
    do_run(2, 3, 3, 1'b0, "after_reset");
    do_run(1, 1, 1, 1'b0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch_low();
    test_narrow();
    test_zero_count();
    test_midrun_and_saturate();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
